// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked byte-addressable data memory for the MEM stage.
// A request walks IDLE -> RD (-> WR for stores) -> RESP. Loads are answered
// from the registered line, and stores read the line, merge the new bytes and
// write it back. Faulting requests skip the array and answer one cycle after
// they are accepted.
module data_mem_ctrl #(
    parameter int    WIDTH     = 64,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "data_in.mem"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [2:0]       req_ctrl,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_fault
);

    localparam int NB   = WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int LW   = $clog2(DEPTH);

    // Size/sign codes: bits [1:0] give log2(bytes), bit 2 marks zero-extension.
    localparam logic [2:0] MEM_BYTE       = 3'd0;
    localparam logic [2:0] MEM_HALFWORD   = 3'd1;
    localparam logic [2:0] MEM_WORD       = 3'd2;
    localparam logic [2:0] MEM_DWORD      = 3'd3;
    localparam logic [2:0] MEM_BYTE_U     = 3'd4;
    localparam logic [2:0] MEM_HALFWORD_U = 3'd5;
    localparam logic [2:0] MEM_WORD_U     = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    line_idx_q;
    logic [OFFW-1:0]  off_q;
    logic [WIDTH-1:0] wdata_q;
    logic [2:0]       ctrl_q;
    logic             write_q;
    logic             fault_q;
    logic [WIDTH-1:0] line_q;
    logic [WIDTH-1:0] last_rdata_q;
    logic             last_fault_q;
    logic             accept;
    logic             req_fault;
    logic [WIDTH-1:0] resp_now;

    function automatic logic [3:0] access_bytes(input logic [2:0] c);
        case (c[1:0])
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // All-ones over the low sz bytes.
    function automatic logic [WIDTH-1:0] size_mask(input logic [3:0] sz);
        logic [WIDTH-1:0] m;
        m = '1;
        if (int'(sz) < NB) m = ~({WIDTH{1'b1}} << {sz, 3'b000});
        return m;
    endfunction

    function automatic logic fault_check(input logic [WIDTH-1:0] addr,
                                         input logic [2:0]       c,
                                         input logic             wr);
        logic [3:0] sz;
        logic [3:0] off4;
        logic       f;
        sz   = access_bytes(c);
        off4 = 4'(addr[OFFW-1:0]);
        f    = 1'b0;
        if ((off4 & (sz - 4'd1)) != 4'd0) f = 1'b1;
        if ((addr >> (OFFW + LW)) != '0) f = 1'b1;
        if (c == 3'b111) f = 1'b1;
        if (WIDTH == 32 && (c == MEM_DWORD || c == MEM_WORD_U)) f = 1'b1;
        if (wr && c[2]) f = 1'b1;
        return f;
    endfunction

    // Pull the addressed bytes down to lane 0 and sign/zero-extend.
    function automatic logic [WIDTH-1:0] load_extract(input logic [WIDTH-1:0] line,
                                                      input logic [OFFW-1:0]  off,
                                                      input logic [2:0]       c);
        logic [WIDTH-1:0] sh;
        logic [WIDTH-1:0] m;
        logic             sgn;
        sh  = line >> {off, 3'b000};
        m   = size_mask(access_bytes(c));
        // m & ~(m >> 1) isolates the top bit of the accessed field.
        sgn = ~c[2] & (|(sh & m & ~(m >> 1)));
        return (sh & m) | (sgn ? ~m : '0);
    endfunction

    // Replace the addressed lanes of the old line with the low bytes of wd.
    function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] old,
                                                     input logic [WIDTH-1:0] wd,
                                                     input logic [OFFW-1:0]  off,
                                                     input logic [2:0]       c);
        logic [WIDTH-1:0] bm;
        bm = size_mask(access_bytes(c)) << {off, 3'b000};
        return (old & ~bm) | ((wd << {off, 3'b000}) & bm);
    endfunction

    assign req_fault = fault_check(req_addr, req_ctrl, req_write);
    assign accept    = req_valid && req_ready;

    // State register; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = ~rst;
                if (req_valid && !rst) state_d = req_fault ? S_RESP : S_RD;
            end
            S_RD:    state_d = write_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request fields at the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_idx_q <= req_addr[OFFW +: LW];
            off_q      <= req_addr[OFFW-1:0];
            wdata_q    <= req_wdata;
            ctrl_q     <= req_ctrl;
            write_q    <= req_write;
            fault_q    <= req_fault;
        end
    end

    // Synchronous array read into line_q; write-back of the merged line in WR.
    always_ff @(posedge clk) begin
        if (state_q == S_RD) line_q <= mem[line_idx_q];
        if (state_q == S_WR && !rst) mem[line_idx_q] <= store_merge(line_q, wdata_q, off_q, ctrl_q);
    end

    assign resp_now = (fault_q || write_q) ? '0 : load_extract(line_q, off_q, ctrl_q);

    // Remember the last response so the outputs hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_rdata_q <= '0;
            last_fault_q <= 1'b0;
        end else if (state_q == S_RESP) begin
            last_rdata_q <= resp_now;
            last_fault_q <= fault_q;
        end
    end

    // Response data: live during RESP, held value otherwise.
    always_comb begin
        resp_rdata = last_rdata_q;
        resp_fault = last_fault_q;
        if (state_q == S_RESP) begin
            resp_rdata = resp_now;
            resp_fault = fault_q;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: scoreboard of expected responses (data, fault,
// arrival cycle) pushed at request time and popped when resp_valid is seen.
module tb_data_mem_ctrl;

    localparam int WIDTH = 64;
    localparam int DEPTH = 1024;

    localparam logic [2:0] MEM_BYTE       = 3'd0;
    localparam logic [2:0] MEM_HALFWORD   = 3'd1;
    localparam logic [2:0] MEM_WORD       = 3'd2;
    localparam logic [2:0] MEM_DWORD      = 3'd3;
    localparam logic [2:0] MEM_BYTE_U     = 3'd4;
    localparam logic [2:0] MEM_HALFWORD_U = 3'd5;
    localparam logic [2:0] MEM_WORD_U     = 3'd6;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_write = 1'b0;
    logic [WIDTH-1:0] req_addr  = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic [2:0]       req_ctrl  = 3'd0;
    logic             req_ready;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_fault;

    typedef struct {
        string       tag;
        logic [63:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    data_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ctrl   (req_ctrl),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every resp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_rdata"}, resp_rdata, mon_e.rdata);
                check({mon_e.tag, "_fault"}, {63'd0, resp_fault}, {63'd0, mon_e.fault});
                check({mon_e.tag, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Drive a request and leave it presented; it is accepted on the posedge
    // following the negedge where req_ready is seen high.
    task automatic send(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [2:0] c,
                        input logic [63:0] exp_rd, input logic exp_f, input bit track);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_ctrl  = c;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        if (track) begin
            e.tag   = tag;
            e.rdata = exp_rd;
            e.fault = exp_f;
            e.cyc   = cyc + (exp_f ? 1 : (wr ? 3 : 2));
            sb.push_back(e);
        end
    endtask

    // Drop req_valid and wait (bounded) for all outstanding responses.
    task automatic drain(input string tag);
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2;
        if (sb.size() != 0) begin
            check({tag, "_drain_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [2:0] c,
                        input logic [63:0] exp_rd, input logic exp_f);
        send(tag, wr, addr, wd, c, exp_rd, exp_f, 1'b1);
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset behaviour
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {63'd0, req_ready}, 64'd0);
        check("rst_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {63'd0, req_ready}, 64'd1);
        check("post_rst_rdata", resp_rdata, 64'd0);
        check("post_rst_fault", {63'd0, resp_fault}, 64'd0);

        // Preload lines 0 and 1 through dword stores
        xfer("pre0", 1'b1, 64'd0, 64'h8877665544332211, MEM_DWORD, 64'd0, 1'b0);
        xfer("pre1", 1'b1, 64'd8, 64'h0123456789ABCDEF, MEM_DWORD, 64'd0, 1'b0);

        // Loads of various sizes and signs
        xfer("lb7",   1'b0, 64'd7, 64'd0, MEM_BYTE,       64'hFFFF_FFFF_FFFF_FF88, 1'b0);
        xfer("lhu2",  1'b0, 64'd2, 64'd0, MEM_HALFWORD_U, 64'h0000_0000_0000_4433, 1'b0);
        xfer("lw4",   1'b0, 64'd4, 64'd0, MEM_WORD,       64'hFFFF_FFFF_8877_6655, 1'b0);
        xfer("lbu7",  1'b0, 64'd7, 64'd0, MEM_BYTE_U,     64'h0000_0000_0000_0088, 1'b0);
        xfer("lh6",   1'b0, 64'd6, 64'd0, MEM_HALFWORD,   64'hFFFF_FFFF_FFFF_8877, 1'b0);
        xfer("lwu4",  1'b0, 64'd4, 64'd0, MEM_WORD_U,     64'h0000_0000_8877_6655, 1'b0);
        xfer("lh0",   1'b0, 64'd0, 64'd0, MEM_HALFWORD,   64'h0000_0000_0000_2211, 1'b0);

        // Byte store with junk in the upper wdata bits, then read back
        xfer("sb3",   1'b1, 64'd3, 64'h1234_5678_9ABC_DEAB, MEM_BYTE, 64'd0, 1'b0);
        xfer("ld0",   1'b0, 64'd0, 64'd0, MEM_DWORD, 64'h8877_6655_AB33_2211, 1'b0);
        // Halfword store into line 1
        xfer("sh10",  1'b1, 64'd10, 64'h0000_0000_0000_BEEF, MEM_HALFWORD, 64'd0, 1'b0);
        xfer("ld8",   1'b0, 64'd8, 64'd0, MEM_DWORD, 64'h0123_4567_BEEF_CDEF, 1'b0);

        // Faults: misaligned, out of range, illegal code, unsigned store
        xfer("lw2_mis",   1'b0, 64'd2, 64'd0, MEM_WORD, 64'd0, 1'b1);
        xfer("sd_oor",    1'b1, 64'(8 * DEPTH), 64'hFFFF_FFFF_FFFF_FFFF, MEM_DWORD, 64'd0, 1'b1);
        xfer("sd4_mis",   1'b1, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, MEM_DWORD, 64'd0, 1'b1);
        xfer("ill_code",  1'b0, 64'd0, 64'd0, 3'b111, 64'd0, 1'b1);
        xfer("sbu_store", 1'b1, 64'd0, 64'h0000_0000_0000_00FF, MEM_BYTE_U, 64'd0, 1'b1);
        xfer("ld0_after", 1'b0, 64'd0, 64'd0, MEM_DWORD, 64'h8877_6655_AB33_2211, 1'b0);
        #1;
        check("hold_rdata", resp_rdata, 64'h8877_6655_AB33_2211);

        // Reset during the WR cycle of a store: no write, no response
        send("sd_abort", 1'b1, 64'd8, 64'h0000_0000_0000_DEAD, MEM_DWORD, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", {63'd0, req_ready}, 64'd1);
        repeat (3) @(negedge clk);
        xfer("ld8_abort", 1'b0, 64'd8, 64'd0, MEM_DWORD, 64'h0123_4567_BEEF_CDEF, 1'b0);

        // Four loads back to back with req_valid held high
        send("q0", 1'b0, 64'd0, 64'd0, MEM_BYTE,     64'h0000_0000_0000_0011, 1'b0, 1'b1);
        send("q1", 1'b0, 64'd3, 64'd0, MEM_BYTE_U,   64'h0000_0000_0000_00AB, 1'b0, 1'b1);
        send("q2", 1'b0, 64'd2, 64'd0, MEM_HALFWORD, 64'hFFFF_FFFF_FFFF_AB33, 1'b0, 1'b1);
        send("q3", 1'b0, 64'd0, 64'd0, MEM_WORD,     64'hFFFF_FFFF_AB33_2211, 1'b0, 1'b1);
        drain("queue");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
